// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, a debug read port, one write port and a per-register busy scoreboard.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] Destination_select,
  input  logic [WIDTH-1:0]  DATA,
  input  logic [ADDR_W-1:0] Source_select_0,
  input  logic [ADDR_W-1:0] Source_select_1,
  input  logic [ADDR_W-1:0] Debug_Source_select,
  output logic [WIDTH-1:0]  out_0,
  output logic [WIDTH-1:0]  out_1,
  output logic [WIDTH-1:0]  Debug_out,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic              raw_hazard,
  output logic [ADDR_W:0]   pending_count
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_count;

  logic              w_wr;
  logic              w_retire_issue;
  logic              w_set;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [WIDTH-1:0]  w_rd0;
  logic [WIDTH-1:0]  w_rd1;
  logic [WIDTH-1:0]  w_rdd;

  // A same-cycle writeback to the source is treated as resolving it only when forwarding exists.
  function automatic logic clear_fwd(input logic              we,
                                     input logic [ADDR_W-1:0] dst,
                                     input logic [ADDR_W-1:0] s);
`ifdef REGFILE_BYPASS_EN
    return we && (dst == s);
`else
    return 1'b0 & we & (dst == s);
`endif
  endfunction

  function automatic logic src_pending(input logic [DEPTH-1:0]  busy,
                                       input logic              we,
                                       input logic [ADDR_W-1:0] dst,
                                       input logic [ADDR_W-1:0] s);
    return (s != '0) && busy[s] && !clear_fwd(we, dst, s);
  endfunction

  function automatic logic [WIDTH-1:0] read_port(input logic [WIDTH-1:0]  stored,
                                                 input logic              we,
                                                 input logic [ADDR_W-1:0] dst,
                                                 input logic [WIDTH-1:0]  wdata,
                                                 input logic [ADDR_W-1:0] s);
    logic [WIDTH-1:0] v;
    v = (s == '0) ? '0 : stored;
`ifdef REGFILE_BYPASS_EN
    if (we && (s != '0) && (dst == s)) v = wdata;
`else
    if (we && (s != '0) && (dst == s)) v = stored;
`endif
    return v;
  endfunction

  assign w_wr           = write_enable && (Destination_select != '0);
  assign w_retire_issue = w_wr && (Destination_select == issue_rd);
  assign issue_ready    = !((issue_rd != '0) && r_busy[issue_rd] && !w_retire_issue);
  assign w_set          = issue_valid && issue_ready && (issue_rd != '0);
  assign w_inc          = w_set && !r_busy[issue_rd];
  assign w_dec          = w_wr && r_busy[Destination_select] &&
                          !(w_set && (issue_rd == Destination_select));

  // Set is applied after clear so a new producer keeps ownership of a retiring register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)  w_busy_nxt[Destination_select] = 1'b0;
    if (w_set) w_busy_nxt[issue_rd]           = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[Destination_select] <= DATA;
    end
  end

  always_comb begin
    w_rd0 = read_port(r_mem[Source_select_0], write_enable, Destination_select, DATA,
                      Source_select_0);
    w_rd1 = read_port(r_mem[Source_select_1], write_enable, Destination_select, DATA,
                      Source_select_1);
    w_rdd = (Debug_Source_select == '0) ? '0 : r_mem[Debug_Source_select];
  end

  // Forwarded data must not leak out while reset is held low.
  assign out_0         = reset ? w_rd0 : '0;
  assign out_1         = reset ? w_rd1 : '0;
  assign Debug_out     = reset ? w_rdd : '0;
  assign raw_hazard    = reset &&
                         (src_pending(r_busy, write_enable, Destination_select, Source_select_0) ||
                          src_pending(r_busy, write_enable, Destination_select, Source_select_1));
  assign pending_count = r_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver pushes model predictions, a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              write_enable;
  logic [ADDR_W-1:0] Destination_select;
  logic [WIDTH-1:0]  DATA;
  logic [ADDR_W-1:0] Source_select_0;
  logic [ADDR_W-1:0] Source_select_1;
  logic [ADDR_W-1:0] Debug_Source_select;
  logic [WIDTH-1:0]  out_0;
  logic [WIDTH-1:0]  out_1;
  logic [WIDTH-1:0]  Debug_out;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              raw_hazard;
  logic [ADDR_W:0]   pending_count;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .Destination_select(Destination_select), .DATA(DATA),
    .Source_select_0(Source_select_0), .Source_select_1(Source_select_1),
    .Debug_Source_select(Debug_Source_select),
    .out_0(out_0), .out_1(out_1), .Debug_out(Debug_out),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .raw_hazard(raw_hazard), .pending_count(pending_count)
  );

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic [31:0] dbg;
    logic        rdy;
    logic        raw;
    logic [31:0] cnt;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_busy[DEPTH];

  function automatic logic [31:0] m_rd(int s, bit rn, bit we, int rd, logic [31:0] d);
    if (!rn || s == 0) return 32'h0;
    if (BYP && we && rd == s) return d;
    return m_mem[s];
  endfunction

  function automatic bit m_pend(int s, bit we, int rd);
    return s != 0 && m_busy[s] && !(BYP && we && rd == s);
  endfunction

  function automatic void chk(string nm, int id, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, id, act, req);
    end
  endfunction

  // Drives one cycle of inputs, predicts the combinational outputs, then advances the model past the edge.
  task automatic cyc(input bit rn, input bit we, input int rd, input logic [31:0] d,
                     input int s0, input int s1, input int dbg, input bit iv, input int ird);
    exp_t e;
    bit   rdy;
    int   n;
    @(posedge clk);
    #1;
    reset = rn; write_enable = we; Destination_select = rd[4:0]; DATA = d;
    Source_select_0 = s0[4:0]; Source_select_1 = s1[4:0]; Debug_Source_select = dbg[4:0];
    issue_valid = iv; issue_rd = ird[4:0];
    if (!rn) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'h0; m_busy[i] = 1'b0; end
    end
    rdy = !(ird != 0 && m_busy[ird] && !(we && rd == ird));
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    e.o0  = m_rd(s0, rn, we, rd, d);
    e.o1  = m_rd(s1, rn, we, rd, d);
    e.dbg = (!rn || dbg == 0) ? 32'h0 : m_mem[dbg];
    e.rdy = rdy;
    e.raw = m_pend(s0, we, rd) || m_pend(s1, we, rd);
    e.cnt = n;
    e.id  = ncyc++;
    q.push_back(e);
    if (rn) begin
      if (we && rd != 0) begin m_mem[rd] = d; m_busy[rd] = 1'b0; end
      if (iv && rdy && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle(input int s0, input int s1, input int dbg);
    cyc(1, 0, 0, 32'h0, s0, s1, dbg, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_0",         e.id, out_0,                  e.o0);
      chk("out_1",         e.id, out_1,                  e.o1);
      chk("Debug_out",     e.id, Debug_out,              e.dbg);
      chk("issue_ready",   e.id, {31'h0, issue_ready},   {31'h0, e.rdy});
      chk("raw_hazard",    e.id, {31'h0, raw_hazard},    {31'h0, e.raw});
      chk("pending_count", e.id, {26'h0, pending_count}, e.cnt);
    end
  end

  function automatic int ra();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b0; write_enable = 1'b0; Destination_select = '0; DATA = '0;
    Source_select_0 = '0; Source_select_1 = '0; Debug_Source_select = '0;
    issue_valid = 1'b0; issue_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'h0; m_busy[i] = 1'b0; end

    // Writes and issues held off by reset, then released.
    cyc(0, 1, 5, 32'hDEADBEEF, 5, 5, 5, 1, 5);
    cyc(0, 1, 5, 32'hDEADBEEF, 5, 5, 5, 1, 5);
    idle(5, 5, 5);
    idle(5, 5, 5);
    // Index 0 is hardwired, index 31 is a normal register.
    cyc(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    cyc(1, 1, 31, 32'hA5A5A5A5, 0, 31, 31, 0, 0);
    idle(0, 31, 31);
    // Single producer lifecycle and WAW refusal.
    cyc(1, 0, 0, 32'h0, 7, 0, 0, 1, 7);
    cyc(1, 0, 0, 32'h0, 7, 0, 0, 1, 7);
    cyc(1, 1, 7, 32'h55, 7, 0, 7, 0, 0);
    idle(7, 0, 7);
    // Issue and retire on the same index: the new producer keeps it busy.
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 1, 3);
    cyc(1, 1, 3, 32'h99, 3, 0, 3, 1, 3);
    idle(3, 0, 3);
    // Forwarding case with a busy register.
    cyc(1, 1, 9, 32'h1111, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 1, 9);
    cyc(1, 1, 9, 32'hCAFE, 0, 9, 9, 0, 0);
    idle(9, 9, 9);
    // Fill every register, then again with an asynchronous reset mid-run.
    cyc(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 32; k++) cyc(1, 0, 0, 32'h0, k, 0, 0, 1, k);
    idle(1, 31, 0);
    for (int k = 1; k < 16; k++) cyc(1, 0, 0, 32'h0, k, 0, 0, 1, k);
    cyc(0, 0, 0, 32'h0, 3, 4, 0, 1, 16);
    idle(3, 4, 0);
    // Randomized traffic biased towards low indices to provoke hazards.
    for (int k = 0; k < 3000; k++)
      cyc(($urandom_range(0, 299) != 0), $urandom_range(0, 1), ra(), $urandom(),
          ra(), ra(), ra(), $urandom_range(0, 1), ra());

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
